// File: rtl/sound_sequencer.sv
// sound_sequencer: turns single-cycle game events into a held sound_type,
// the 8 kHz sample strobe and the sample index for the audio player.
// Optional build macro: SOUND_SEQ_CHOMP_QUEUE_EN (1-deep chomp queue).
package sound_seq_pkg;
  typedef enum logic [2:0] {
    SND_NONE      = 3'd0,
    SND_CHOMP     = 3'd1,
    SND_EAT_GHOST = 3'd2,
    SND_DEATH     = 3'd3,
    SND_INTRO     = 3'd4
  } sound_t;
endpackage

module sound_sequencer
  import sound_seq_pkg::*;
#(
  parameter int CLK_HZ    = 25_000_000,
  parameter int SAMPLE_HZ = 8_000,
  parameter int CHOMP_LEN = 5736,
  parameter int GHOST_LEN = 4096,
  parameter int DEATH_LEN = 8000,
  parameter int INTRO_LEN = 8191
) (
  input  logic        clk_25MHZ,
  input  logic        rst_n,
  input  logic        evt_chomp,
  input  logic        evt_eat_ghost,
  input  logic        evt_death,
  input  logic        evt_intro,
  input  logic        mute,
  output logic        clk_8KHZ,
  output sound_t      sound_type,
  output logic [12:0] sample_idx,
  output logic        playing,
  output logic        clip_done
);

  localparam int DIV = CLK_HZ / SAMPLE_HZ;
  localparam int DW  = $clog2(DIV);

  typedef enum logic {IDLE, PLAY} state_t;

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          strobe_q, strobe_d;
  state_t        state_q, state_d;
  sound_t        cur_q, cur_d;
  logic [12:0]   idx_q, idx_d;
  logic          done_q, done_d;
  sound_t        evt_win;
  logic          at_last;
`ifdef SOUND_SEQ_CHOMP_QUEUE_EN
  logic          pend_q, pend_d;
`endif

  // Last valid sample index of each clip.
  function automatic logic [12:0] clip_last(input sound_t s);
    case (s)
      SND_CHOMP:     clip_last = 13'(CHOMP_LEN - 1);
      SND_EAT_GHOST: clip_last = 13'(GHOST_LEN - 1);
      SND_DEATH:     clip_last = 13'(DEATH_LEN - 1);
      SND_INTRO:     clip_last = 13'(INTRO_LEN - 1);
      default:       clip_last = 13'd0;
    endcase
  endfunction

  // Free-running divider; strobe is registered so it coincides with div_cnt==DIV-1.
  always_comb begin
    div_cnt_d = (div_cnt_q == DW'(DIV - 1)) ? '0 : div_cnt_q + DW'(1);
    strobe_d  = (div_cnt_d == DW'(DIV - 1));
  end

  // Priority encode simultaneous events; the enum ordering doubles as priority rank.
  always_comb begin
    evt_win = SND_NONE;
    if (evt_intro)          evt_win = SND_INTRO;
    else if (evt_death)     evt_win = SND_DEATH;
    else if (evt_eat_ghost) evt_win = SND_EAT_GHOST;
    else if (evt_chomp)     evt_win = SND_CHOMP;
  end

  // Next-state logic: start, preempt, advance and end-of-clip handling.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    at_last = strobe_q && (idx_q == clip_last(cur_q));
`ifdef SOUND_SEQ_CHOMP_QUEUE_EN
    pend_d  = pend_q;
`endif
    case (state_q)
      IDLE: begin
        if (evt_win != SND_NONE) begin
          state_d = PLAY;
          cur_d   = evt_win;
          idx_d   = '0;
        end
      end
      PLAY: begin
        if (evt_win > cur_q) begin
          // Strictly higher priority restarts; an accepted event also masks a final strobe.
          cur_d = evt_win;
          idx_d = '0;
`ifdef SOUND_SEQ_CHOMP_QUEUE_EN
          pend_d = 1'b0;
`endif
        end else begin
`ifdef SOUND_SEQ_CHOMP_QUEUE_EN
          if (evt_chomp && (cur_q == SND_CHOMP)) pend_d = 1'b1;
          if (at_last) begin
            done_d = 1'b1;
            idx_d  = '0;
            if (pend_d) begin
              pend_d = 1'b0;
            end else begin
              state_d = IDLE;
              cur_d   = SND_NONE;
            end
          end else if (strobe_q) begin
            idx_d = idx_q + 13'd1;
          end
`else
          if (at_last) begin
            done_d  = 1'b1;
            idx_d   = '0;
            state_d = IDLE;
            cur_d   = SND_NONE;
          end else if (strobe_q) begin
            idx_d = idx_q + 13'd1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any clip silently.
  always_ff @(posedge clk_25MHZ or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      strobe_q  <= 1'b0;
      state_q   <= IDLE;
      cur_q     <= SND_NONE;
      idx_q     <= '0;
      done_q    <= 1'b0;
`ifdef SOUND_SEQ_CHOMP_QUEUE_EN
      pend_q    <= 1'b0;
`endif
    end else begin
      div_cnt_q <= div_cnt_d;
      strobe_q  <= strobe_d;
      state_q   <= state_d;
      cur_q     <= cur_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
`ifdef SOUND_SEQ_CHOMP_QUEUE_EN
      pend_q    <= pend_d;
`endif
    end
  end

  assign clk_8KHZ   = strobe_q;
  assign sound_type = mute ? SND_NONE : cur_q;
  assign sample_idx = idx_q;
  assign playing    = (state_q == PLAY);
  assign clip_done  = done_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Table-driven bench for sound_sequencer with DIV=10 and short clips.
// Cycle n is the interval after the n-th rising edge following reset release;
// strobes are expected at cycles 9,19,29,... Events driven in cycle n show in cycle n+1.
module tb_sound_sequencer;
  import sound_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        evt_chomp = 1'b0, evt_eat_ghost = 1'b0, evt_death = 1'b0, evt_intro = 1'b0;
  logic        mute = 1'b0;
  logic        clk_8KHZ;
  sound_t      sound_type;
  logic [12:0] sample_idx;
  logic        playing;
  logic        clip_done;

  sound_sequencer #(
    .CLK_HZ(80), .SAMPLE_HZ(8),
    .CHOMP_LEN(4), .GHOST_LEN(3), .DEATH_LEN(5), .INTRO_LEN(6)
  ) dut (
    .clk_25MHZ(clk), .rst_n(rst_n),
    .evt_chomp(evt_chomp), .evt_eat_ghost(evt_eat_ghost),
    .evt_death(evt_death), .evt_intro(evt_intro), .mute(mute),
    .clk_8KHZ(clk_8KHZ), .sound_type(sound_type), .sample_idx(sample_idx),
    .playing(playing), .clip_done(clip_done)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] E0 = 4'b0000, EC = 4'b0001, EG = 4'b0010, ED = 4'b0100, EI = 4'b1000;

  typedef struct {
    int       cyc;   // cycle in which inputs are driven
    logic [3:0] evt; // {intro, death, ghost, chomp}
    logic     mute;
    logic     play;  // expected outputs in cycle cyc+1
    sound_t   snd;
    int       idx;
    logic     done;
  } vec_t;

  typedef struct {
    int     cyc;
    logic   play;
    sound_t snd;
    int     idx;
    logic   done;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_now = 0;
  int   done_cnt = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", nm, cyc_now, act, req);
    end
  endtask

  task automatic add(input int c, input logic [3:0] e, input logic m,
                     input logic p, input sound_t s, input int ix, input logic d);
    vec_t v;
    v.cyc = c; v.evt = e; v.mute = m; v.play = p; v.snd = s; v.idx = ix; v.done = d;
    vecs.push_back(v);
  endtask

  task automatic clear_evts();
    evt_chomp = 1'b0; evt_eat_ghost = 1'b0; evt_death = 1'b0; evt_intro = 1'b0;
  endtask

  // Advance one cycle, then check the strobe and any scoreboard entries due now.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc_now++;
    chk("clk_8KHZ", int'(clk_8KHZ), int'(cyc_now % 10 == 9));
    if (clip_done && cyc_now >= 253 && cyc_now <= 335) done_cnt++;
    while (sb.size() > 0 && sb[0].cyc == cyc_now) begin
      e = sb.pop_front();
      $display("cyc %0d: playing=%0b snd=%0d idx=%0d done=%0b", cyc_now, playing,
               int'(sound_type), sample_idx, clip_done);
      chk("playing", int'(playing), int'(e.play));
      chk("sound_type", int'(sound_type), int'(e.snd));
      chk("sample_idx", int'(sample_idx), e.idx);
      chk("clip_done", int'(clip_done), int'(e.done));
    end
  endtask

  initial begin
    vec_t v;
    exp_t e;
    // A: single chomp, 4 samples
    add(2,   EC, 0, 1, SND_CHOMP, 0, 0);
    add(9,   E0, 0, 1, SND_CHOMP, 1, 0);
    add(19,  E0, 0, 1, SND_CHOMP, 2, 0);
    add(29,  E0, 0, 1, SND_CHOMP, 3, 0);
    add(38,  E0, 0, 1, SND_CHOMP, 3, 0);
    add(39,  E0, 0, 0, SND_NONE,  0, 1);
    add(40,  E0, 0, 0, SND_NONE,  0, 0);
    // B: chomp+death together -> death wins
    add(42,  EC|ED, 0, 1, SND_DEATH, 0, 0);
    add(49,  E0, 0, 1, SND_DEATH, 1, 0);
    add(79,  E0, 0, 1, SND_DEATH, 4, 0);
    add(89,  E0, 0, 0, SND_NONE,  0, 1);
    add(90,  E0, 0, 0, SND_NONE,  0, 0);
    // C: intro preempts death at idx 2; lower/equal events ignored
    add(92,  ED, 0, 1, SND_DEATH, 0, 0);
    add(109, E0, 0, 1, SND_DEATH, 2, 0);
    add(112, EI, 0, 1, SND_INTRO, 0, 0);
    add(115, EC, 0, 1, SND_INTRO, 0, 0);
    add(119, E0, 0, 1, SND_INTRO, 1, 0);
    add(125, EI, 0, 1, SND_INTRO, 1, 0);
    add(127, ED, 0, 1, SND_INTRO, 1, 0);
    add(159, E0, 0, 1, SND_INTRO, 5, 0);
    add(169, E0, 0, 0, SND_NONE,  0, 1);
    // D: preempting event on the final strobe suppresses clip_done
    add(172, EG, 0, 1, SND_EAT_GHOST, 0, 0);
    add(189, E0, 0, 1, SND_EAT_GHOST, 2, 0);
    add(199, ED, 0, 1, SND_DEATH, 0, 0);
    add(239, E0, 0, 1, SND_DEATH, 4, 0);
    add(249, E0, 0, 0, SND_NONE,  0, 1);
    // E: extra chomps during chomp
    add(252, EC, 0, 1, SND_CHOMP, 0, 0);
    add(255, EC, 0, 1, SND_CHOMP, 0, 0);
    add(265, EC, 0, 1, SND_CHOMP, 1, 0);
`ifdef SOUND_SEQ_CHOMP_QUEUE_EN
    add(289, E0, 0, 1, SND_CHOMP, 0, 1);
    add(290, E0, 0, 1, SND_CHOMP, 0, 0);
    add(329, E0, 0, 0, SND_NONE,  0, 1);
`else
    add(289, E0, 0, 0, SND_NONE,  0, 1);
    add(290, E0, 0, 0, SND_NONE,  0, 0);
    add(329, E0, 0, 0, SND_NONE,  0, 0);
`endif
    add(330, E0, 0, 0, SND_NONE,  0, 0);
    // F: mute gates only sound_type
    add(332, EG, 0, 1, SND_EAT_GHOST, 0, 0);
    add(335, E0, 1, 1, SND_NONE,  0, 0);
    add(339, E0, 1, 1, SND_NONE,  1, 0);
    add(345, E0, 0, 1, SND_EAT_GHOST, 1, 0);
    add(347, E0, 1, 1, SND_NONE,  1, 0);
    add(359, E0, 1, 0, SND_NONE,  0, 1);
    add(361, E0, 0, 0, SND_NONE,  0, 0);

    // Reset state
    #12;
    chk("rst_clk_8KHZ", int'(clk_8KHZ), 0);
    chk("rst_sound_type", int'(sound_type), int'(SND_NONE));
    chk("rst_sample_idx", int'(sample_idx), 0);
    chk("rst_playing", int'(playing), 0);
    chk("rst_clip_done", int'(clip_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc_now = 0;

    foreach (vecs[i]) begin
      v = vecs[i];
      while (cyc_now < v.cyc) begin
        tick();
        clear_evts();
      end
      evt_chomp     = v.evt[0];
      evt_eat_ghost = v.evt[1];
      evt_death     = v.evt[2];
      evt_intro     = v.evt[3];
      mute          = v.mute;
      e.cyc = v.cyc + 1; e.play = v.play; e.snd = v.snd; e.idx = v.idx; e.done = v.done;
      sb.push_back(e);
    end
    tick();
    clear_evts();
    chk("scoreboard_drained", sb.size(), 0);
`ifdef SOUND_SEQ_CHOMP_QUEUE_EN
    chk("chomp_done_pulses", done_cnt, 2);
`else
    chk("chomp_done_pulses", done_cnt, 1);
`endif

    // Reset in the middle of a ghost clip at idx 1
    while (cyc_now < 365) begin tick(); clear_evts(); end
    evt_eat_ghost = 1'b1;
    tick();
    clear_evts();
    chk("ghost2_playing", int'(playing), 1);
    chk("ghost2_sound", int'(sound_type), int'(SND_EAT_GHOST));
    while (cyc_now < 372) begin tick(); clear_evts(); end
    chk("ghost2_idx", int'(sample_idx), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_clk_8KHZ", int'(clk_8KHZ), 0);
    chk("arst_sound_type", int'(sound_type), int'(SND_NONE));
    chk("arst_sample_idx", int'(sample_idx), 0);
    chk("arst_playing", int'(playing), 0);
    chk("arst_clip_done", int'(clip_done), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("arst_hold_done", int'(clip_done), 0);
      chk("arst_hold_playing", int'(playing), 0);
    end
    rst_n = 1'b1;
    cyc_now = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      chk("post_rst_done", int'(clip_done), 0);
    end
    chk("post_rst_playing", int'(playing), 0);
    chk("post_rst_sound", int'(sound_type), int'(SND_NONE));
    chk("post_rst_idx", int'(sample_idx), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
